// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if -- request/status bundle between the ULA top level and
// the reset sequencer.
//   req          active-high internal reset requests
//   ext_rst_n    readback of the open-drain CPU reset line, active low
//   hold_cycles  hold length, sampled when HOLD is entered
//   cause_clr    clears the sticky cause register
//   dom_rst_n    per-domain resets, active low
//   cpu_rst_drive  1 = pull the CPU reset line low
//   busy         1 while any domain is held in reset
//   cause        sticky cause; bit NSRC = external CPU reset
// master: requester side (top level / bench); slave: the sequencer.
interface reset_sequencer_if #(
  parameter int NSRC   = 4,
  parameter int HOLD_W = 8,
  parameter int NDOM   = 3
) ();
  logic [NSRC-1:0]   req;
  logic              ext_rst_n;
  logic [HOLD_W-1:0] hold_cycles;
  logic              cause_clr;
  logic [NDOM-1:0]   dom_rst_n;
  logic              cpu_rst_drive;
  logic              busy;
  logic [NSRC:0]     cause;

  modport master (
    output req, ext_rst_n, hold_cycles, cause_clr,
    input  dom_rst_n, cpu_rst_drive, busy, cause
  );

  modport slave (
    input  req, ext_rst_n, hold_cycles, cause_clr,
    output dom_rst_n, cpu_rst_drive, busy, cause
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer -- filters NSRC internal reset requests plus the external
// CPU reset line, holds all reset domains for a programmable time, then
// releases them in index order with STAGE_GAP cycles between domains.
// Records a sticky cause for the service ROM.
//   clk28  system clock
//   rst_n  synchronous active-low reset
//   bus    reset_sequencer_if slave modport (requests in, domain resets,
//          CPU reset drive, busy and cause out)
module reset_sequencer #(
  parameter int              NSRC       = 4,
  parameter int              FILT_W     = 3,
  parameter logic [NSRC-1:0] PULSE_MASK = '0,
  parameter int              HOLD_W     = 8,
  parameter int              NDOM       = 3,
  parameter int              STAGE_GAP  = 4
) (
  input  logic clk28,
  input  logic rst_n,
  reset_sequencer_if.slave bus
);

  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {S_ASSERT, S_HOLD, S_RELEASE, S_RUN} state_e;

  state_e            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [GW-1:0]     gap_q;
  logic [NDOM-1:0]   dom_q;
  logic [NDOM-1:0]   dom_nxt;
  logic              drv_q;
  logic              drv_dly_q;
  logic [FILT_W-1:0] ext_cnt_q;
  logic [NSRC:0]     cause_q;
  logic [NSRC:0]     recog;
  logic              any_req;

  // Request recognition, one lane per source.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    if (PULSE_MASK[i]) begin : g_pulse
      // A single capture flop gives pulses the same registered recognition
      // point as the level filters: sampled at edge n, acted on at n+1.
      logic pls_q;
      always_ff @(posedge clk28) begin
        if (!rst_n) pls_q <= 1'b0;
        else        pls_q <= bus.req[i];
      end
      assign recog[i] = pls_q;
    end else begin : g_level
      logic [FILT_W-1:0] cnt_q;
      always_ff @(posedge clk28) begin
        if (!rst_n)              cnt_q <= '0;
        else if (!bus.req[i])    cnt_q <= '0;
        else if (!(&cnt_q))      cnt_q <= cnt_q + 1'b1;
      end
      assign recog[i] = &cnt_q;
    end
  end

  // External CPU reset filter. While we drive the line, and for one cycle
  // after letting go, the readback is our own echo and must not count.
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      ext_cnt_q <= '0;
      drv_dly_q <= 1'b1;
    end else begin
      drv_dly_q <= drv_q;
      if (drv_q || drv_dly_q || bus.ext_rst_n) ext_cnt_q <= '0;
      else if (!(&ext_cnt_q))                  ext_cnt_q <= ext_cnt_q + 1'b1;
    end
  end
  assign recog[NSRC] = &ext_cnt_q;

  assign any_req = |recog;

  // Sticky cause: set has priority over clear for the same bit.
  always_ff @(posedge clk28) begin
    if (!rst_n) cause_q <= '0;
    else        cause_q <= (bus.cause_clr ? '0 : cause_q) | recog;
  end

  // Domain release shifts a 1 in from domain 0 upward.
  assign dom_nxt = (dom_q << 1) | NDOM'(1);

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q <= S_HOLD;
      hold_q  <= bus.hold_cycles;
      gap_q   <= '0;
      dom_q   <= '0;
      drv_q   <= 1'b1;
    end else if (any_req) begin
      // A request overrides any release or countdown in flight.
      state_q <= S_ASSERT;
      gap_q   <= '0;
      dom_q   <= '0;
      drv_q   <= 1'b1;
    end else begin
      case (state_q)
        S_ASSERT: begin
          state_q <= S_HOLD;
          hold_q  <= bus.hold_cycles;
        end
        S_HOLD: begin
          if (hold_q == '0) begin
            dom_q   <= NDOM'(1);
            gap_q   <= '0;
            drv_q   <= (NDOM == 1) ? 1'b0 : 1'b1;
            state_q <= (NDOM == 1) ? S_RUN : S_RELEASE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        S_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_q <= '0;
            dom_q <= dom_nxt;
            drv_q <= ~dom_nxt[NDOM-1];
            if (&dom_nxt) state_q <= S_RUN;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_RUN: ;
        default: state_q <= S_ASSERT;
      endcase
    end
  end

  assign bus.dom_rst_n     = dom_q;
  assign bus.cpu_rst_drive = drv_q;
  assign bus.busy          = ~&dom_q;
  assign bus.cause         = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer -- scenario tasks for reset_sequencer. Domain rise/fall
// events are expected in a queue when stimulus is applied and matched
// against the events the monitor observes on dom_rst_n.
module tb_reset_sequencer;
  localparam int NSRC = 2, FILT_W = 3, HOLD_W = 8, NDOM = 3, STAGE_GAP = 4;
  localparam logic [NSRC-1:0] PMASK = 2'b10;
  localparam int HOLD = 10;
  localparam int K_RISE = 0, K_FALL = 1;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk28 = ~clk28;

  reset_sequencer_if #(.NSRC(NSRC), .HOLD_W(HOLD_W), .NDOM(NDOM)) bus ();

  reset_sequencer #(
    .NSRC(NSRC), .FILT_W(FILT_W), .PULSE_MASK(PMASK),
    .HOLD_W(HOLD_W), .NDOM(NDOM), .STAGE_GAP(STAGE_GAP)
  ) dut (
    .clk28(clk28),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {int cyc; int kind; int dom;} ev_t;
  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  edge_no  = 0;

  always @(posedge clk28) edge_no <= edge_no + 1;

  // Monitor: turn dom_rst_n changes into events and score them.
  logic [NDOM-1:0] prev_dom;
  bit              prev_ok = 0;
  always @(negedge clk28) begin
    ev_t obs[$];
    ev_t o, e;
    if (!$isunknown(bus.dom_rst_n)) begin
      if (prev_ok) begin
        if (prev_dom != '0 && bus.dom_rst_n == '0) obs.push_back('{edge_no, K_FALL, 0});
        for (int k = 0; k < NDOM; k++)
          if (!prev_dom[k] && bus.dom_rst_n[k]) obs.push_back('{edge_no, K_RISE, k});
      end
      prev_dom = bus.dom_rst_n;
      prev_ok  = 1;
    end
    while (obs.size() > 0) begin
      o = obs.pop_front();
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got cyc=%0d kind=%0d dom=%0d, want none", o.cyc, o.kind, o.dom);
      end else begin
        e = exp_q.pop_front();
        if (o.cyc !== e.cyc || o.kind !== e.kind || o.dom !== e.dom) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d kind=%0d dom=%0d, want cyc=%0d kind=%0d dom=%0d",
                   o.cyc, o.kind, o.dom, e.cyc, e.kind, e.dom);
        end
      end
    end
  end

  task automatic push_ev(input int cyc, input int kind, input int dom);
    exp_q.push_back('{cyc, kind, dom});
  endtask

  // Full release sequence whose domain 0 rises at edge 'first'.
  task automatic push_release(input int first);
    for (int k = 0; k < NDOM; k++) push_ev(first + k * STAGE_GAP, K_RISE, k);
  endtask

  task automatic step();
    @(negedge clk28);
  endtask

  task automatic wait_edge(input int target);
    while (edge_no < target) @(negedge clk28);
  endtask

  task automatic test_reset();
    int r;
    bus.req = '0; bus.ext_rst_n = 1'b1; bus.cause_clr = 1'b0; bus.hold_cycles = HOLD_W'(HOLD);
    rst_n = 1'b0; step(); step();
    n_checks++; if (bus.dom_rst_n !== 3'b000) begin n_fail++; $display("FAIL rst_dom: got %b want 000", bus.dom_rst_n); end
    n_checks++; if (bus.cpu_rst_drive !== 1'b1) begin n_fail++; $display("FAIL rst_drv: got %b want 1", bus.cpu_rst_drive); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
    n_checks++; if (bus.cause !== 3'b000) begin n_fail++; $display("FAIL rst_cause: got %b want 000", bus.cause); end
    rst_n = 1'b1; r = edge_no;
    push_release(r + HOLD + 1);
    wait_edge(r + HOLD);
    n_checks++; if (bus.dom_rst_n !== 3'b000) begin n_fail++; $display("FAIL hold_end_dom: got %b want 000", bus.dom_rst_n); end
    wait_edge(r + 18);
    n_checks++; if (bus.dom_rst_n !== 3'b011 || bus.cpu_rst_drive !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL pre_last: got dom=%b drv=%b busy=%b want 011/1/1", bus.dom_rst_n, bus.cpu_rst_drive, bus.busy);
    end
    wait_edge(r + 19);
    n_checks++; if (bus.dom_rst_n !== 3'b111 || bus.cpu_rst_drive !== 1'b0 || bus.busy !== 1'b0 || bus.cause !== 3'b000) begin
      n_fail++; $display("FAIL run_state: got dom=%b drv=%b busy=%b cause=%b want 111/0/0/000",
                         bus.dom_rst_n, bus.cpu_rst_drive, bus.busy, bus.cause);
    end
    step();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_level();
    int t;
    step(); t = edge_no; bus.req[0] = 1'b1;
    wait_edge(t + 6); bus.req[0] = 1'b0;
    wait_edge(t + 10);
    n_checks++; if (bus.dom_rst_n !== 3'b111 || bus.cause !== 3'b000) begin
      n_fail++; $display("FAIL level6_ignored: got dom=%b cause=%b want 111/000", bus.dom_rst_n, bus.cause);
    end
    t = edge_no;
    push_ev(t + 8, K_FALL, 0); push_release(t + 8 + HOLD + 2);
    bus.req[0] = 1'b1;
    wait_edge(t + 7);
    n_checks++; if (bus.dom_rst_n !== 3'b111) begin n_fail++; $display("FAIL level7_early: got %b want 111", bus.dom_rst_n); end
    bus.req[0] = 1'b0;
    wait_edge(t + 8);
    n_checks++; if (bus.dom_rst_n !== 3'b000 || bus.busy !== 1'b1 || bus.cpu_rst_drive !== 1'b1 || bus.cause !== 3'b001) begin
      n_fail++; $display("FAIL level7_assert: got dom=%b busy=%b drv=%b cause=%b want 000/1/1/001",
                         bus.dom_rst_n, bus.busy, bus.cpu_rst_drive, bus.cause);
    end
    wait_edge(t + 8 + HOLD + 2 + 8); step();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL level_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_pulse();
    int t;
    step(); t = edge_no;
    push_ev(t + 2, K_FALL, 0); push_release(t + 2 + HOLD + 2);
    bus.req[1] = 1'b1; step(); bus.req[1] = 1'b0;
    n_checks++; if (bus.dom_rst_n !== 3'b111) begin n_fail++; $display("FAIL pulse_early: got %b want 111", bus.dom_rst_n); end
    wait_edge(t + 2);
    n_checks++; if (bus.dom_rst_n !== 3'b000 || bus.cause !== 3'b011) begin
      n_fail++; $display("FAIL pulse_assert: got dom=%b cause=%b want 000/011", bus.dom_rst_n, bus.cause);
    end
    wait_edge(t + 2 + HOLD + 2 + 8); step();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL pulse_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_release_abort();
    int t, a;
    step(); t = edge_no; a = t + 2;
    push_ev(a, K_FALL, 0); push_ev(a + HOLD + 2, K_RISE, 0);
    bus.req[1] = 1'b1; step(); bus.req[1] = 1'b0;
    wait_edge(a + 6);
    push_ev(a + 14, K_FALL, 0); push_release(a + 14 + HOLD + 2);
    bus.req[0] = 1'b1;
    wait_edge(a + 13);
    n_checks++; if (bus.dom_rst_n !== 3'b001 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre: got dom=%b busy=%b want 001/1", bus.dom_rst_n, bus.busy);
    end
    bus.req[0] = 1'b0;
    wait_edge(a + 14);
    n_checks++; if (bus.dom_rst_n !== 3'b000 || bus.cpu_rst_drive !== 1'b1) begin
      n_fail++; $display("FAIL abort_assert: got dom=%b drv=%b want 000/1", bus.dom_rst_n, bus.cpu_rst_drive);
    end
    wait_edge(a + 14 + HOLD + 2 + 8); step();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL abort_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_ext();
    int t, r;
    // Line held low by the block itself (and its release echo) is ignored.
    step(); push_ev(edge_no + 1, K_FALL, 0);
    rst_n = 1'b0; step(); step(); rst_n = 1'b1; r = edge_no;
    push_release(r + HOLD + 1);
    step(); bus.ext_rst_n = 1'b0;
    wait_edge(r + 19); bus.ext_rst_n = 1'b1;
    wait_edge(r + 24);
    n_checks++; if (bus.dom_rst_n !== 3'b111 || bus.cause !== 3'b000) begin
      n_fail++; $display("FAIL ext_echo: got dom=%b cause=%b want 111/000", bus.dom_rst_n, bus.cause);
    end
    // Short glitch.
    t = edge_no; bus.ext_rst_n = 1'b0;
    wait_edge(t + 3); bus.ext_rst_n = 1'b1;
    wait_edge(t + 10);
    n_checks++; if (bus.dom_rst_n !== 3'b111 || bus.cause !== 3'b000) begin
      n_fail++; $display("FAIL ext_glitch: got dom=%b cause=%b want 111/000", bus.dom_rst_n, bus.cause);
    end
    // Genuine external reset.
    t = edge_no;
    push_ev(t + 8, K_FALL, 0); push_release(t + 8 + HOLD + 2);
    bus.ext_rst_n = 1'b0;
    wait_edge(t + 7); bus.ext_rst_n = 1'b1;
    wait_edge(t + 8);
    n_checks++; if (bus.dom_rst_n !== 3'b000 || bus.cpu_rst_drive !== 1'b1 || bus.cause !== 3'b100) begin
      n_fail++; $display("FAIL ext_assert: got dom=%b drv=%b cause=%b want 000/1/100", bus.dom_rst_n, bus.cpu_rst_drive, bus.cause);
    end
    wait_edge(t + 8 + HOLD + 2 + 8); step();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ext_pending: got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_cause_rst();
    int t, p, r;
    // Clear coinciding with a live recognition: bit 0 survives.
    step(); t = edge_no;
    push_ev(t + 8, K_FALL, 0); push_release(t + 9 + HOLD + 2);
    bus.req[0] = 1'b1;
    wait_edge(t + 7); bus.cause_clr = 1'b1;
    wait_edge(t + 8); bus.cause_clr = 1'b0; bus.req[0] = 1'b0;
    n_checks++; if (bus.cause !== 3'b001) begin n_fail++; $display("FAIL set_wins: got %b want 001", bus.cause); end
    wait_edge(t + 9 + HOLD + 2 + 8);
    // Clear in the cycle a pulse is sampled.
    t = edge_no; p = t + 1;
    push_ev(p + 1, K_FALL, 0); push_ev(p + 1 + HOLD + 2, K_RISE, 0);
    bus.req[1] = 1'b1; bus.cause_clr = 1'b1; step(); bus.req[1] = 1'b0; bus.cause_clr = 1'b0;
    n_checks++; if (bus.cause !== 3'b000) begin n_fail++; $display("FAIL clr_cycle: got %b want 000", bus.cause); end
    wait_edge(p + 1);
    n_checks++; if (bus.cause !== 3'b010) begin n_fail++; $display("FAIL clr_pulse: got %b want 010", bus.cause); end
    // Reset in the middle of the release sequence.
    wait_edge(p + 14);
    n_checks++; if (bus.dom_rst_n !== 3'b001) begin n_fail++; $display("FAIL mid_release: got %b want 001", bus.dom_rst_n); end
    push_ev(p + 15, K_FALL, 0);
    rst_n = 1'b0;
    wait_edge(p + 15);
    n_checks++; if (bus.dom_rst_n !== 3'b000 || bus.busy !== 1'b1 || bus.cause !== 3'b000 || bus.cpu_rst_drive !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst: got dom=%b busy=%b cause=%b drv=%b want 000/1/000/1",
                         bus.dom_rst_n, bus.busy, bus.cause, bus.cpu_rst_drive);
    end
    step(); rst_n = 1'b1; r = edge_no;
    push_release(r + HOLD + 1);
    wait_edge(r + HOLD + 1 + 8); step();
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL final_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_level();
    test_pulse();
    test_release_abort();
    test_ext();
    test_cause_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
